// File: rtl/config_pkg.sv
// Shared configuration package for the region attribute checker.
//   cva6_cfg_t          : compiled configuration carrying the three region tables
//                         (non-idempotent, execute, cached), each with a rule count
//                         and per-rule base/length arrays of NrMaxRules entries.
//   region_chk_state_e  : state encoding of the checker FSM.
//   nrules()            : number of scan steps needed for a given configuration.
package config_pkg;

  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    logic [31:0]                 NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0] NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0] NonIdempotentLength;
    logic [31:0]                 NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0] ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0] ExecuteRegionLength;
    logic [31:0]                 NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0] CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0] CachedRegionLength;
  } cva6_cfg_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StResp
  } region_chk_state_e;

  // Largest rule count across the three tables, at least 1. Counts above the table
  // capacity are clamped so the scan index always stays inside the arrays.
  function automatic int unsigned nrules(cva6_cfg_t cfg);
    int unsigned n;
    n = 1;
    if (cfg.NrNonIdempotentRules > n) n = cfg.NrNonIdempotentRules;
    if (cfg.NrExecuteRegionRules > n) n = cfg.NrExecuteRegionRules;
    if (cfg.NrCachedRegionRules > n)  n = cfg.NrCachedRegionRules;
    if (n > NrMaxRules)               n = NrMaxRules;
    return n;
  endfunction

endpackage

// File: rtl/region_range_match.sv
// Combinational single-rule address range check.
//   en_i     : rule index is populated in its table
//   base_i   : region base address
//   length_i : region length (0 = empty region)
//   addr_i   : address under test
//   match_o  : base <= addr < base + length, evaluated without wrap-around
module region_range_match (
  input  logic        en_i,
  input  logic [63:0] base_i,
  input  logic [63:0] length_i,
  input  logic [63:0] addr_i,
  output logic        match_o
);

  logic [64:0] addr_ext;
  logic [64:0] lo;
  logic [64:0] hi;

  // 65-bit arithmetic so a region ending at 2^64 does not wrap to 0
  assign addr_ext = {1'b0, addr_i};
  assign lo       = {1'b0, base_i};
  assign hi       = {1'b0, base_i} + {1'b0, length_i};

  assign match_o = en_i && (length_i != 64'd0) && (addr_ext >= lo) && (addr_ext < hi);

endmodule

// File: rtl/region_attr_checker.sv
// Classifies a physical address against the execute, cached and non-idempotent
// region tables of the compiled configuration. One rule index is scanned per cycle
// across all three tables; the result is held until the consumer accepts it.
//   clk_i, rst_i               : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o    : query handshake (ready only when idle)
//   req_addr_i                 : address to classify, latched on acceptance
//   rsp_valid_o/rsp_ready_i    : result handshake
//   rsp_exec_o/rsp_cached_o/rsp_nonidem_o : attributes, 0 while rsp_valid_o is 0
//   busy_o                     : FSM not idle
//   query_cnt_o                : saturating accepted-query count, only when the
//                                CVA6_REGION_CHK_PERF_EN macro is defined
module region_attr_checker
  import config_pkg::*;
#(
  parameter cva6_cfg_t CVA6Cfg = '0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_exec_o,
  output logic        rsp_cached_o,
  output logic        rsp_nonidem_o,
  output logic        busy_o
`ifdef CVA6_REGION_CHK_PERF_EN
  ,
  output logic [31:0] query_cnt_o
`endif
);

  localparam int unsigned NRules   = nrules(CVA6Cfg);
  localparam int unsigned IdxW     = (NRules > 1) ? $clog2(NRules) : 1;
  localparam int unsigned RuleIdxW = $clog2(NrMaxRules);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NRules - 1);

  region_chk_state_e state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [63:0]       addr_q, addr_d;
  logic              exec_q, exec_d;
  logic              cached_q, cached_d;
  logic              nonidem_q, nonidem_d;

  logic [RuleIdxW-1:0] rule_idx;
  logic [31:0]         idx_ext;
  logic                exec_hit, cached_hit, nonidem_hit;

  assign rule_idx = RuleIdxW'(idx_q);
  assign idx_ext  = 32'(idx_q);

  region_range_match u_match_exec (
    .en_i     (idx_ext < CVA6Cfg.NrExecuteRegionRules),
    .base_i   (CVA6Cfg.ExecuteRegionAddrBase[rule_idx]),
    .length_i (CVA6Cfg.ExecuteRegionLength[rule_idx]),
    .addr_i   (addr_q),
    .match_o  (exec_hit)
  );

  region_range_match u_match_cached (
    .en_i     (idx_ext < CVA6Cfg.NrCachedRegionRules),
    .base_i   (CVA6Cfg.CachedRegionAddrBase[rule_idx]),
    .length_i (CVA6Cfg.CachedRegionLength[rule_idx]),
    .addr_i   (addr_q),
    .match_o  (cached_hit)
  );

  region_range_match u_match_nonidem (
    .en_i     (idx_ext < CVA6Cfg.NrNonIdempotentRules),
    .base_i   (CVA6Cfg.NonIdempotentAddrBase[rule_idx]),
    .length_i (CVA6Cfg.NonIdempotentLength[rule_idx]),
    .addr_i   (addr_q),
    .match_o  (nonidem_hit)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    exec_d    = exec_q;
    cached_d  = cached_q;
    nonidem_d = nonidem_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d   = StScan;
          idx_d     = '0;
          addr_d    = req_addr_i;
          exec_d    = 1'b0;
          cached_d  = 1'b0;
          nonidem_d = 1'b0;
        end
      end
      StScan: begin
        exec_d    = exec_q | exec_hit;
        cached_d  = cached_q | cached_hit;
        nonidem_d = nonidem_q | nonidem_hit;
        if (idx_q == LastIdx) begin
          state_d = StResp;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StResp: begin
        // Back to idle on handshake; a new request is only seen next cycle
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      addr_q    <= '0;
      exec_q    <= 1'b0;
      cached_q  <= 1'b0;
      nonidem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      exec_q    <= exec_d;
      cached_q  <= cached_d;
      nonidem_q <= nonidem_d;
    end
  end

  assign req_ready_o   = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign rsp_valid_o   = (state_q == StResp);
  assign rsp_exec_o    = rsp_valid_o & exec_q;
  assign rsp_cached_o  = rsp_valid_o & cached_q;
  assign rsp_nonidem_o = rsp_valid_o & nonidem_q;

`ifdef CVA6_REGION_CHK_PERF_EN
  logic [31:0] query_cnt_q;
  logic        accept;

  assign accept = (state_q == StIdle) && req_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      query_cnt_q <= '0;
    end else if (accept && (query_cnt_q != 32'hFFFF_FFFF)) begin
      query_cnt_q <= query_cnt_q + 32'd1;
    end
  end

  assign query_cnt_o = query_cnt_q;
`endif

endmodule

// File: tb/tb_region_attr_checker.sv
// Directed bench for region_attr_checker with a three-rule configuration:
//   exec    {0x0+0x1000, 0x1_0000+0x1_0000, 0x8000_0000+0x4000_0000}
//   cached  {0x8000_0000+0x4000_0000}
//   nonidem two rules of length 0 (never match)
module tb_region_attr_checker;
  import config_pkg::*;

  function automatic cva6_cfg_t tb_cfg();
    cva6_cfg_t c;
    c = '0;
    c.NrExecuteRegionRules     = 32'd3;
    c.ExecuteRegionAddrBase[0] = 64'h0;
    c.ExecuteRegionLength[0]   = 64'h1000;
    c.ExecuteRegionAddrBase[1] = 64'h1_0000;
    c.ExecuteRegionLength[1]   = 64'h1_0000;
    c.ExecuteRegionAddrBase[2] = 64'h8000_0000;
    c.ExecuteRegionLength[2]   = 64'h4000_0000;
    c.NrCachedRegionRules      = 32'd1;
    c.CachedRegionAddrBase[0]  = 64'h8000_0000;
    c.CachedRegionLength[0]    = 64'h4000_0000;
    c.NrNonIdempotentRules     = 32'd2;
    c.NonIdempotentAddrBase[0] = 64'h8000_0000;
    c.NonIdempotentLength[0]   = 64'h0;
    c.NonIdempotentAddrBase[1] = 64'h0;
    c.NonIdempotentLength[1]   = 64'h0;
    return c;
  endfunction

  localparam cva6_cfg_t TbCfg = tb_cfg();
  localparam int ExpLat = 3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_exec;
  logic        rsp_cached;
  logic        rsp_nonidem;
  logic        busy;
`ifdef CVA6_REGION_CHK_PERF_EN
  logic [31:0] query_cnt;
`endif

  int vectors;
  int miscompares;

  region_attr_checker #(
    .CVA6Cfg (TbCfg)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_exec_o    (rsp_exec),
    .rsp_cached_o  (rsp_cached),
    .rsp_nonidem_o (rsp_nonidem),
    .busy_o        (busy)
`ifdef CVA6_REGION_CHK_PERF_EN
    ,
    .query_cnt_o   (query_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for rsp_valid and returns the number of cycles taken
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_query(input logic [63:0] addr, input logic e, input logic c,
                           input logic n, input string tag);
    int lat;
    req_addr  = addr;
    req_valid = 1'b1;
    check({tag, "/ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_addr  = 64'hDEAD_BEEF_DEAD_BEEF;
    check({tag, "/busy"}, busy, 1);
    check({tag, "/rsp_zero"}, {rsp_valid, rsp_exec, rsp_cached, rsp_nonidem}, 0);
    wait_rsp(lat);
    check({tag, "/lat"}, lat, ExpLat);
    check({tag, "/attr"}, {rsp_exec, rsp_cached, rsp_nonidem}, {e, c, n});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "/done"}, {rsp_valid, req_ready, busy, rsp_exec}, 4'b0100);
  endtask

  initial begin
    int lat;
    logic seen_valid;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    rsp_ready   = 1'b0;

    repeat (2) tick();
    check("reset_state", {req_ready, rsp_valid, busy, rsp_exec, rsp_cached, rsp_nonidem},
          6'b100000);
`ifdef CVA6_REGION_CHK_PERF_EN
    check("reset_cnt", query_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    run_query(64'h8000_1000, 1'b1, 1'b1, 1'b0, "q_8000_1000");
    run_query(64'h0000_0FFF, 1'b1, 1'b0, 1'b0, "q_0fff");
    run_query(64'h0000_1000, 1'b0, 1'b0, 1'b0, "q_1000");
    run_query(64'hBFFF_FFFF, 1'b1, 1'b1, 1'b0, "q_bfff_ffff");
`ifdef CVA6_REGION_CHK_PERF_EN
    check("cnt_after_4", query_cnt, 4);
`endif
    run_query(64'hC000_0000, 1'b0, 1'b0, 1'b0, "q_c000_0000");
    run_query(64'h0001_FFFF, 1'b1, 1'b0, 1'b0, "q_1_ffff");
    run_query(64'h0002_0000, 1'b0, 1'b0, 1'b0, "q_2_0000");
    run_query(64'hFFFF_FFFF_8000_1000, 1'b0, 1'b0, 1'b0, "q_high");

    // Back-pressure: result held for 5 cycles while a new request is presented
    req_addr  = 64'h8000_1000;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_addr  = 64'h0000_1000;
    req_valid = 1'b1;  // ignored while scanning
    wait_rsp(lat);
    check("bp/lat", lat, ExpLat);
    req_addr = 64'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp/hold%0d", i),
            {rsp_valid, rsp_exec, rsp_cached, rsp_nonidem, req_ready}, 5'b11100);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp/no_same_cycle_accept", {req_ready, busy, rsp_valid}, 3'b100);
    tick();
    req_valid = 1'b0;
    check("bp/accept_next", busy, 1);
    wait_rsp(lat);
    check("bp/new_lat", lat, ExpLat);
    check("bp/new_attr", {rsp_exec, rsp_cached, rsp_nonidem}, 3'b100);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset pulse two cycles into the scan drops the query
    req_addr  = 64'h8000_1000;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst/async", {busy, rsp_valid, req_ready, rsp_exec}, 4'b0010);
    #1 rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen_valid = 1'b1;
    end
    check("rst/no_rsp", seen_valid, 0);
`ifdef CVA6_REGION_CHK_PERF_EN
    check("rst/cnt", query_cnt, 0);
`endif
    run_query(64'h0001_0004, 1'b1, 1'b0, 1'b0, "q_after_rst");

`ifdef CVA6_REGION_CHK_PERF_EN
    force dut.query_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.query_cnt_q;
    run_query(64'h0, 1'b1, 1'b0, 1'b0, "sat_a");
    check("sat/reach", query_cnt, 32'hFFFF_FFFF);
    run_query(64'h0, 1'b1, 1'b0, 1'b0, "sat_b");
    check("sat/hold", query_cnt, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
